lock_sequencer: RTL and testbench
=================================

# lock_sequencer

Lock-acquisition controller for the PDH loop. It sweeps the laser actuator DAC across a configured code range until the transmission signal crosses a threshold. It then hands the DAC to the PID core: it clears the PID, enables it, qualifies the lock and monitors for loss, with optional automatic relock. It sits between the AXI command registers, the PID core (enable/reset) and the DAC1 output mux.

## Interface
Parameters:
- DAC_WIDTH, 14, DAC code width (offset binary, midscale 14'h2000)
- SIG_WIDTH, 16, signed transmission/threshold width
- DWELL_WIDTH, 16, dwell and hold counter width

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  single-cycle pulse; begins acquisition from IDLE or FAULT
- abort_i  in  1  single-cycle pulse; return to IDLE from any state
- auto_relock_i  in  1  on lock loss: 1 = resweep, 0 = FAULT
- sweep_min_i / sweep_max_i  in  DAC_WIDTH  sweep bounds, unsigned
- sweep_step_i  in  DAC_WIDTH  code increment per step (0 treated as 1)
- dwell_i  in  DWELL_WIDTH  cycles per sweep step (0 treated as 1)
- hold_i  in  DWELL_WIDTH  consecutive qualifying cycles for lock, settle and loss (0 treated as 1)
- lock_thresh_i / unlock_thresh_i  in  SIG_WIDTH  signed thresholds
- trans_i  in  SIG_WIDTH  signed transmission sample, one per clk
- dac_o  out  DAC_WIDTH  sweep code to DAC mux
- dac_sel_o  out  1  0 = dac_o drives DAC1, 1 = PID drives DAC1
- pid_enable_o  out  1  PID core enable
- pid_rst_o  out  1  one-cycle PID state clear
- locked_o  out  1  lock qualified
- cfg_err_o  out  1  last start rejected (min > max)
- res_code_o  out  DAC_WIDTH  dac_o value captured at resonance detection
- loss_cnt_o  out  8  lock-loss count, saturates at 255
- state_o  out  3  current state encoding

## Operation
- Config snapshot: start_i copies min, max, step, dwell, hold and the thresholds into internal registers. Changing an input mid-run has no effect until the next start_i.
- States:
  - IDLE=0
  - SWEEP=1
  - ENGAGE=2
  - SETTLE=3
  - LOCKED=4
  - FAULT=5
- IDLE:
  - dac_sel_o=0, pid_enable_o=0, dac_o holds its value.
  - start_i with min ≤ max → SWEEP, dac_o←min, cfg_err_o←0.
  - start_i with min > max → FAULT, cfg_err_o←1.
- SWEEP:
  - Dwell counter counts dwell cycles per step, then the step fires.
  - Step computes next = dac_o + step at DAC_WIDTH+1 bits. If next > max, dac_o←min (sawtooth wrap); otherwise dac_o←next.
  - Qualifier counts consecutive cycles with trans_i ≥ lock_thresh (signed compare) and clears on any miss.
  - Count reaching hold → res_code_o←dac_o, → ENGAGE.
- ENGAGE: exactly one cycle. pid_rst_o=1, dac_sel_o=1, pid_enable_o=1 → SETTLE.
- SETTLE:
  - Counts hold cycles. Any cycle with trans_i < unlock_thresh → loss handling.
  - Completion → LOCKED, locked_o=1.
- LOCKED:
  - Qualifier counts consecutive cycles with trans_i < unlock_thresh.
  - Count reaching hold → loss handling.
- Loss handling:
  - loss_cnt_o increments (saturating), locked_o=0, pid_enable_o=0, dac_sel_o=0, dac_o←res_code_o.
  - auto_relock_i=1 → SWEEP restarting at min. auto_relock_i=0 → FAULT.
- FAULT: PID disabled, dac_sel_o=0, dac_o holds. start_i → re-snapshot and re-check as from IDLE.
- Priority: abort_i > all transitions > start_i. start_i is ignored in SWEEP, ENGAGE, SETTLE and LOCKED.

## Timing
- Reset values:
  - state=IDLE
  - dac_o=14'h2000, res_code_o=14'h2000
  - dac_sel_o=0, pid_enable_o=0, pid_rst_o=0
  - locked_o=0, cfg_err_o=0, loss_cnt_o=0
  - all counters 0
- All outputs are registered.
- start_i at edge N → state SWEEP and dac_o=min visible after edge N.
- The first step occurs dwell edges later; each subsequent step follows after another dwell edges.
- trans_i is qualifying at edges N..N+H−1 (H=hold) → state ENGAGE after edge N+H−1 → SETTLE one edge later.
- pid_rst_o is high for exactly one cycle, coincident with the first cycle of dac_sel_o=1.
- Resonance detection at the same edge as a dwell step: detection wins, and res_code_o takes the pre-step dac_o.
- abort_i is effective at the next edge: IDLE, outputs as after reset except dac_o, res_code_o and loss_cnt_o, which hold.
- Reset asserted mid-operation → immediate return to reset values.

## Structure
- Package lock_seq_pkg holds:
  - lock_state_t enum with the encodings above
  - DAC_MIDSCALE constant
  - LOSS_CNT_MAX constant
- One sub-module, lock_qual_counter: consecutive-cycle qualifier with inputs clk, rst, clear, hit and hold, and output done. It is instantiated twice, once for lock and once for loss.

## Test plan
- Basic sweep: min=100, max=130, step=10, dwell=4, trans_i held low → dac_o sequence 100,110,120,130,100, with each value held 4 cycles.
- Acquire: trans_i ≥ lock_thresh=1000 for 3 cycles at dac_o=120, hold=3 → res_code_o=120, a single pid_rst_o pulse, SETTLE, LOCKED after 3 further good cycles.
- Loss with auto_relock_i=1: in LOCKED, trans_i < unlock_thresh=500 for 3 cycles → loss_cnt_o=1, dac_sel_o=0, SWEEP restarting at 100. A 2-cycle dip must not trigger loss.
- Loss with auto_relock_i=0 → FAULT. start_i → SWEEP. Repeat 256 losses → loss_cnt_o stays 255.
- Config checks: min=200, max=100 → FAULT, cfg_err_o=1. step=0 and dwell=0 → dac_o advances by 1 every cycle.
- Abort and reset priority: abort_i and start_i in the same IDLE cycle → stays IDLE. rst asserted in LOCKED → all outputs at reset values immediately.

Source files
------------

// File: rtl/lock_seq_pkg.sv
// Shared state encoding and constants for the PDH lock-acquisition sequencer.
package lock_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SWEEP  = 3'd1,
        ST_ENGAGE = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAULT  = 3'd5
    } lock_state_t;

    localparam logic [13:0] DAC_MIDSCALE = 14'h2000;
    localparam logic [7:0]  LOSS_CNT_MAX = 8'd255;

endpackage

// File: rtl/lock_qual_counter.sv
// Consecutive-cycle qualifier: done fires on the cycle the hold-th consecutive hit arrives.
module lock_qual_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             hit,
    input  logic [WIDTH-1:0] hold,
    output logic             done
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH:0]   hold_eff;
    logic [WIDTH:0]   cnt_inc;

    always_comb begin
        hold_eff = (hold == '0) ? (WIDTH+1)'(1) : {1'b0, hold};
        cnt_inc  = {1'b0, cnt_q} + (WIDTH+1)'(1);
        // Combinational so the owning FSM can transition on the qualifying edge itself.
        done     = hit && !clear && (cnt_inc >= hold_eff);
        cnt_d    = cnt_q;
        if (clear || !hit || done) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_inc[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lock_sequencer.sv
// Sweeps the laser DAC until transmission crosses threshold, then hands off to the PID
// and supervises the lock with optional automatic relock.
module lock_sequencer
    import lock_seq_pkg::*;
#(
    parameter int DAC_WIDTH   = 14,
    parameter int SIG_WIDTH   = 16,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic                   auto_relock_i,
    input  logic [DAC_WIDTH-1:0]   sweep_min_i,
    input  logic [DAC_WIDTH-1:0]   sweep_max_i,
    input  logic [DAC_WIDTH-1:0]   sweep_step_i,
    input  logic [DWELL_WIDTH-1:0] dwell_i,
    input  logic [DWELL_WIDTH-1:0] hold_i,
    input  logic [SIG_WIDTH-1:0]   lock_thresh_i,
    input  logic [SIG_WIDTH-1:0]   unlock_thresh_i,
    input  logic [SIG_WIDTH-1:0]   trans_i,
    output logic [DAC_WIDTH-1:0]   dac_o,
    output logic                   dac_sel_o,
    output logic                   pid_enable_o,
    output logic                   pid_rst_o,
    output logic                   locked_o,
    output logic                   cfg_err_o,
    output logic [DAC_WIDTH-1:0]   res_code_o,
    output logic [7:0]             loss_cnt_o,
    output logic [2:0]             state_o
);

    localparam logic [DAC_WIDTH-1:0] DAC_RESET = DAC_WIDTH'(DAC_MIDSCALE);

    lock_state_t state_q, state_d;
    logic [DAC_WIDTH-1:0]   dac_q, dac_d;
    logic [DAC_WIDTH-1:0]   res_q, res_d;
    logic [7:0]             loss_q, loss_d;
    logic                   cfg_err_q, cfg_err_d;
    logic                   sel_q, sel_d;
    logic                   pid_rst_q, pid_rst_d;
    logic                   locked_q, locked_d;
    logic [DWELL_WIDTH-1:0] dwell_cnt_q, dwell_cnt_d;

    logic [DAC_WIDTH-1:0]   min_q, max_q, step_q;
    logic [DWELL_WIDTH-1:0] dwell_q, hold_q;
    logic [SIG_WIDTH-1:0]   lock_th_q, unlock_th_q;
    logic                   cfg_load;

    logic [DAC_WIDTH:0]     dac_next;
    logic                   trans_ge_lock, trans_lt_unlock;
    logic                   lock_clear, lock_hit, lock_done;
    logic                   loss_clear, loss_done;
    logic                   lost;

    assign trans_ge_lock   = $signed(trans_i) >= $signed(lock_th_q);
    assign trans_lt_unlock = $signed(trans_i) <  $signed(unlock_th_q);

    // One qualifier serves both acquisition (SWEEP) and the settle window (SETTLE).
    assign lock_clear = !(state_q == ST_SWEEP || state_q == ST_SETTLE);
    assign lock_hit   = (state_q == ST_SETTLE) ? !trans_lt_unlock : trans_ge_lock;
    assign loss_clear = (state_q != ST_LOCKED);

    lock_qual_counter #(.WIDTH(DWELL_WIDTH)) u_lock_qual (
        .clk   (clk),
        .rst   (rst),
        .clear (lock_clear),
        .hit   (lock_hit),
        .hold  (hold_q),
        .done  (lock_done)
    );

    lock_qual_counter #(.WIDTH(DWELL_WIDTH)) u_loss_qual (
        .clk   (clk),
        .rst   (rst),
        .clear (loss_clear),
        .hit   (trans_lt_unlock),
        .hold  (hold_q),
        .done  (loss_done)
    );

    always_comb begin
        state_d     = state_q;
        dac_d       = dac_q;
        res_d       = res_q;
        loss_d      = loss_q;
        cfg_err_d   = cfg_err_q;
        dwell_cnt_d = dwell_cnt_q;
        cfg_load    = 1'b0;
        lost        = 1'b0;
        dac_next    = {1'b0, dac_q} + {1'b0, step_q};

        if (abort_i) begin
            state_d     = ST_IDLE;
            cfg_err_d   = 1'b0;
            dwell_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_FAULT: begin
                    if (start_i) begin
                        cfg_load = 1'b1;
                        if (sweep_min_i > sweep_max_i) begin
                            state_d   = ST_FAULT;
                            cfg_err_d = 1'b1;
                        end else begin
                            state_d     = ST_SWEEP;
                            dac_d       = sweep_min_i;
                            cfg_err_d   = 1'b0;
                            dwell_cnt_d = '0;
                        end
                    end
                end
                ST_SWEEP: begin
                    // Detection takes precedence over a coincident dwell step.
                    if (lock_done) begin
                        res_d       = dac_q;
                        state_d     = ST_ENGAGE;
                        dwell_cnt_d = '0;
                    end else if (dwell_cnt_q == dwell_q - DWELL_WIDTH'(1)) begin
                        dwell_cnt_d = '0;
                        dac_d       = (dac_next > {1'b0, max_q}) ? min_q : dac_next[DAC_WIDTH-1:0];
                    end else begin
                        dwell_cnt_d = dwell_cnt_q + DWELL_WIDTH'(1);
                    end
                end
                ST_ENGAGE: begin
                    state_d = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (trans_lt_unlock) begin
                        lost = 1'b1;
                    end else if (lock_done) begin
                        state_d = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (loss_done) begin
                        lost = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (lost) begin
            loss_d = (loss_q == LOSS_CNT_MAX) ? loss_q : loss_q + 8'd1;
            if (auto_relock_i) begin
                state_d     = ST_SWEEP;
                dac_d       = min_q;
                dwell_cnt_d = '0;
            end else begin
                state_d = ST_FAULT;
                dac_d   = res_q;
            end
        end

        sel_d     = (state_d == ST_ENGAGE) || (state_d == ST_SETTLE) || (state_d == ST_LOCKED);
        pid_rst_d = (state_d == ST_ENGAGE);
        locked_d  = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dac_q       <= DAC_RESET;
            res_q       <= DAC_RESET;
            loss_q      <= '0;
            cfg_err_q   <= 1'b0;
            sel_q       <= 1'b0;
            pid_rst_q   <= 1'b0;
            locked_q    <= 1'b0;
            dwell_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            dac_q       <= dac_d;
            res_q       <= res_d;
            loss_q      <= loss_d;
            cfg_err_q   <= cfg_err_d;
            sel_q       <= sel_d;
            pid_rst_q   <= pid_rst_d;
            locked_q    <= locked_d;
            dwell_cnt_q <= dwell_cnt_d;
        end
    end

    // Zero step/dwell are stored as 1 so the sweep datapath never sees them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_q       <= '0;
            max_q       <= '0;
            step_q      <= '0;
            dwell_q     <= '0;
            hold_q      <= '0;
            lock_th_q   <= '0;
            unlock_th_q <= '0;
        end else if (cfg_load) begin
            min_q       <= sweep_min_i;
            max_q       <= sweep_max_i;
            step_q      <= (sweep_step_i == '0) ? DAC_WIDTH'(1) : sweep_step_i;
            dwell_q     <= (dwell_i == '0) ? DWELL_WIDTH'(1) : dwell_i;
            hold_q      <= hold_i;
            lock_th_q   <= lock_thresh_i;
            unlock_th_q <= unlock_thresh_i;
        end
    end

    assign dac_o        = dac_q;
    assign dac_sel_o    = sel_q;
    assign pid_enable_o = sel_q;
    assign pid_rst_o    = pid_rst_q;
    assign locked_o     = locked_q;
    assign cfg_err_o    = cfg_err_q;
    assign res_code_o   = res_q;
    assign loss_cnt_o   = loss_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Self-checking bench for lock_sequencer: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of the sequencing rules.
`timescale 1ns/1ps
module tb_lock_sequencer;

    localparam int DW = 14;
    localparam int SW = 16;
    localparam int WW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_i = 1'b0, abort_i = 1'b0, auto_relock_i = 1'b1;
    logic [DW-1:0] sweep_min = '0, sweep_max = '0, sweep_step = '0;
    logic [WW-1:0] dwell = '0, hold = '0;
    logic signed [SW-1:0] lock_th = '0, unlock_th = '0, trans = '0;

    logic [DW-1:0] dac_o, res_code_o;
    logic          dac_sel_o, pid_enable_o, pid_rst_o, locked_o, cfg_err_o;
    logic [7:0]    loss_cnt_o;
    logic [2:0]    state_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lock_sequencer #(.DAC_WIDTH(DW), .SIG_WIDTH(SW), .DWELL_WIDTH(WW)) dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .auto_relock_i   (auto_relock_i),
        .sweep_min_i     (sweep_min),
        .sweep_max_i     (sweep_max),
        .sweep_step_i    (sweep_step),
        .dwell_i         (dwell),
        .hold_i          (hold),
        .lock_thresh_i   (lock_th),
        .unlock_thresh_i (unlock_th),
        .trans_i         (trans),
        .dac_o           (dac_o),
        .dac_sel_o       (dac_sel_o),
        .pid_enable_o    (pid_enable_o),
        .pid_rst_o       (pid_rst_o),
        .locked_o        (locked_o),
        .cfg_err_o       (cfg_err_o),
        .res_code_o      (res_code_o),
        .loss_cnt_o      (loss_cnt_o),
        .state_o         (state_o)
    );

    // ---------------- behavioural model ----------------
    int m_state, m_dac, m_res, m_loss, m_cfg, m_sel, m_en, m_prst, m_lock;
    int c_min, c_max, c_step, c_dwell, c_hold, c_lk, c_ul;
    int m_dw, m_q, m_l;

    function automatic int nz(int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_reset();
        m_state = 0; m_dac = 8192; m_res = 8192; m_loss = 0; m_cfg = 0;
        m_sel = 0; m_en = 0; m_prst = 0; m_lock = 0;
        c_min = 0; c_max = 0; c_step = 1; c_dwell = 1; c_hold = 1; c_lk = 0; c_ul = 0;
        m_dw = 0; m_q = 0; m_l = 0;
    endtask

    task automatic model_step();
        int t, ns, nx;
        bit lost;
        t = int'(trans);
        ns = m_state;
        lost = 0;
        if (abort_i) begin
            ns = 0;
            m_cfg = 0;
        end else begin
            case (m_state)
                0, 5: if (start_i) begin
                    c_min = int'(sweep_min); c_max = int'(sweep_max);
                    c_step = nz(int'(sweep_step)); c_dwell = nz(int'(dwell)); c_hold = nz(int'(hold));
                    c_lk = int'(lock_th); c_ul = int'(unlock_th);
                    if (c_min > c_max) begin
                        ns = 5; m_cfg = 1;
                    end else begin
                        ns = 1; m_cfg = 0; m_dac = c_min; m_dw = 0; m_q = 0;
                    end
                end
                1: begin
                    m_q = (t >= c_lk) ? m_q + 1 : 0;
                    if (m_q >= c_hold) begin
                        m_res = m_dac; ns = 2;
                    end else begin
                        m_dw++;
                        if (m_dw == c_dwell) begin
                            m_dw = 0;
                            nx = m_dac + c_step;
                            m_dac = (nx > c_max) ? c_min : nx;
                        end
                    end
                end
                2: begin ns = 3; m_q = 0; end
                3: begin
                    if (t < c_ul) lost = 1;
                    else begin
                        m_q++;
                        if (m_q >= c_hold) begin ns = 4; m_l = 0; end
                    end
                end
                4: begin
                    m_l = (t < c_ul) ? m_l + 1 : 0;
                    if (m_l >= c_hold) lost = 1;
                end
                default: ns = 0;
            endcase
        end
        if (lost) begin
            if (m_loss < 255) m_loss++;
            if (auto_relock_i) begin
                ns = 1; m_dac = c_min; m_dw = 0; m_q = 0;
            end else begin
                ns = 5; m_dac = m_res;
            end
        end
        m_state = ns;
        m_sel  = (ns >= 2 && ns <= 4) ? 1 : 0;
        m_en   = m_sel;
        m_prst = (ns == 2) ? 1 : 0;
        m_lock = (ns == 4) ? 1 : 0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        vectors++;
        if (int'(state_o) != m_state || int'(dac_o) != m_dac || int'(res_code_o) != m_res ||
            int'(loss_cnt_o) != m_loss || int'(cfg_err_o) != m_cfg || int'(dac_sel_o) != m_sel ||
            int'(pid_enable_o) != m_en || int'(pid_rst_o) != m_prst || int'(locked_o) != m_lock) begin
            miscompares++;
            $display("FAIL model_cmp t=%0t got st=%0d dac=%0d res=%0d loss=%0d cfg=%0d sel=%0d en=%0d prst=%0d lk=%0d exp st=%0d dac=%0d res=%0d loss=%0d cfg=%0d sel=%0d en=%0d prst=%0d lk=%0d",
                     $time, state_o, dac_o, res_code_o, loss_cnt_o, cfg_err_o, dac_sel_o, pid_enable_o,
                     pid_rst_o, locked_o, m_state, m_dac, m_res, m_loss, m_cfg, m_sel, m_en, m_prst, m_lock);
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
        else $display("ok   %s = %0d", name, act);
    endtask

    task automatic do_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_state(input int s, input int budget);
        int n;
        n = 0;
        while (int'(state_o) != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (int'(state_o) != s) begin
            miscompares++;
            $display("FAIL wait_state: got state %0d expected %0d within %0d cycles", state_o, s, budget);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, int'(state_o), 0);
        check({tag, "_dac"}, int'(dac_o), 8192);
        check({tag, "_res"}, int'(res_code_o), 8192);
        check({tag, "_sel"}, int'(dac_sel_o), 0);
        check({tag, "_en"}, int'(pid_enable_o), 0);
        check({tag, "_prst"}, int'(pid_rst_o), 0);
        check({tag, "_locked"}, int'(locked_o), 0);
        check({tag, "_cfgerr"}, int'(cfg_err_o), 0);
        check({tag, "_loss"}, int'(loss_cnt_o), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int seq[5] = '{100, 110, 120, 130, 100};
        int n, tmp, lk, mx;

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Basic sweep: sawtooth 100..130 step 10, 4 cycles per code
        sweep_min = 14'd100; sweep_max = 14'd130; sweep_step = 14'd10;
        dwell = 16'd4; hold = 16'd3; lock_th = 16'sd1000; unlock_th = 16'sd500;
        trans = 16'sd0; auto_relock_i = 1'b1;
        do_start();
        check("sweep_state", int'(state_o), 1);
        for (int k = 0; k < 20; k++) begin
            check($sformatf("sweep_dac_k%0d", k), int'(dac_o), seq[k / 4]);
            @(negedge clk);
        end

        // Acquire at 120 with detection coinciding with the dwell step edge
        n = 0;
        while (int'(dac_o) != 120 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("reach_120", int'(dac_o), 120);
        @(negedge clk);
        trans = 16'sd2000;
        @(negedge clk);
        @(negedge clk);
        check("pre_detect_state", int'(state_o), 1);
        @(negedge clk);
        check("engage_state", int'(state_o), 2);
        check("engage_res", int'(res_code_o), 120);
        check("engage_dac_held", int'(dac_o), 120);
        check("engage_prst", int'(pid_rst_o), 1);
        check("engage_sel", int'(dac_sel_o), 1);
        @(negedge clk);
        check("settle_state", int'(state_o), 3);
        check("settle_prst", int'(pid_rst_o), 0);
        check("settle_en", int'(pid_enable_o), 1);
        @(negedge clk);
        @(negedge clk);
        check("settle_still", int'(state_o), 3);
        @(negedge clk);
        check("locked_state", int'(state_o), 4);
        check("locked_flag", int'(locked_o), 1);

        // Two-cycle dip is tolerated, three-cycle dip relocks
        trans = 16'sd100;
        @(negedge clk);
        @(negedge clk);
        trans = 16'sd2000;
        @(negedge clk);
        @(negedge clk);
        check("dip2_locked", int'(state_o), 4);
        trans = 16'sd100;
        @(negedge clk);
        @(negedge clk);
        check("dip_pre_loss", int'(state_o), 4);
        @(negedge clk);
        check("loss_state", int'(state_o), 1);
        check("loss_cnt1", int'(loss_cnt_o), 1);
        check("loss_dac_min", int'(dac_o), 100);
        check("loss_sel", int'(dac_sel_o), 0);
        check("loss_locked", int'(locked_o), 0);

        // Loss without relock goes to FAULT
        auto_relock_i = 1'b0;
        trans = 16'sd2000;
        wait_state(4, 20);
        trans = 16'sd100;
        wait_state(5, 10);
        check("fault_loss_cnt", int'(loss_cnt_o), 2);
        check("fault_en", int'(pid_enable_o), 0);
        check("fault_dac_res", int'(dac_o), int'(res_code_o) == 100 ? 100 : -1);

        // Saturation of the loss counter
        hold = 16'd1;
        for (int i = 0; i < 258; i++) begin
            do_start();
            trans = 16'sd2000;
            wait_state(4, 10);
            trans = -16'sd100;
            wait_state(5, 5);
        end
        check("loss_saturated", int'(loss_cnt_o), 255);
        trans = 16'sd0;

        // Config checks
        sweep_min = 14'd200; sweep_max = 14'd100;
        do_start();
        check("cfg_bad_state", int'(state_o), 5);
        check("cfg_bad_err", int'(cfg_err_o), 1);
        sweep_min = 14'd0; sweep_max = 14'd1000; sweep_step = 14'd0; dwell = 16'd0;
        do_start();
        check("cfg_ok_err", int'(cfg_err_o), 0);
        check("zero_dac0", int'(dac_o), 0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("zero_step_dac%0d", k), int'(dac_o), k);
        end

        // Abort wins over a coincident start
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("abort_idle", int'(state_o), 0);
        abort_i = 1'b1;
        start_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        start_i = 1'b0;
        check("abort_start_idle", int'(state_o), 0);

        // Randomized traffic checked by the model each cycle
        for (int cyc = 0; cyc < 5000; cyc++) begin
            if ($urandom_range(0, 29) == 0) begin
                sweep_min  = DW'($urandom_range(0, 60));
                mx = int'(sweep_min) + int'($urandom_range(0, 90)) - 10;
                sweep_max  = DW'((mx < 0) ? 0 : mx);
                sweep_step = DW'($urandom_range(0, 7));
                dwell      = WW'($urandom_range(0, 3));
                hold       = WW'($urandom_range(0, 4));
                lk         = int'($urandom_range(0, 600)) - 100;
                lock_th    = SW'(lk);
                unlock_th  = SW'(lk - int'($urandom_range(0, 300)));
                auto_relock_i = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 9) == 0) begin
                tmp = int'($urandom_range(0, 1000)) - 300;
                trans = SW'(tmp);
            end
            start_i = ($urandom_range(0, 39) == 0);
            abort_i = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        start_i = 1'b0;
        abort_i = 1'b0;

        // Asynchronous reset while LOCKED
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        sweep_min = 14'd10; sweep_max = 14'd20; sweep_step = 14'd1; dwell = 16'd1;
        hold = 16'd2; lock_th = 16'sd100; unlock_th = 16'sd50; trans = 16'sd500;
        auto_relock_i = 1'b1;
        do_start();
        wait_state(4, 20);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
